// File: rtl/datamover_cmd_arbiter.sv
// Round-robin arbiter sharing one DataMover command/status pair; TAG carries the requester index.
// One-cycle grant pulse, command held until pi_ready; status routed back one cycle later, never stalled.
module datamover_cmd_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [NUM_REQ*72-1:0] pi_req_command,
  input  logic [NUM_REQ-1:0]   pi_req_valid,
  output logic [NUM_REQ-1:0]   po_req_ready,
  output logic [7:0]           po_req_sts_tdata,
  output logic [NUM_REQ-1:0]   po_req_sts_tvalid,
  output logic [71:0]          po_command,
  output logic                 po_valid,
  input  logic                 pi_ready,
  input  logic [7:0]           pi_sts_tdata,
  input  logic                 pi_sts_tvalid,
  output logic                 po_sts_tready,
  output logic                 po_orphan_sts,
  output logic                 po_busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t              state, state_next;
  logic [PW-1:0]       ptr;
  logic [3:0]          cnt [NUM_REQ];
  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  dec;
  logic                grant_vld;
  logic [PW-1:0]       grant_idx;
  logic [71:0]         cmd_sel;
  logic [3:0]          sts_tag;
  logic                sts_fire;
  logic                sts_hit;
  logic                any_cnt;
  logic                unused_cmd_tag;

  assign sts_tag  = pi_sts_tdata[3:0];
  assign sts_fire = pi_sts_tvalid & po_sts_tready;
  assign po_valid = (state == ISSUE);

  always_comb begin
    eligible = '0;
    dec      = '0;
    any_cnt  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = pi_req_valid[i] && (cnt[i] < MAX_CNT);
      dec[i]      = sts_fire && (sts_tag == 4'(i)) && (cnt[i] != 4'd0);
      any_cnt     = any_cnt | (cnt[i] != 4'd0);
    end
  end

  assign sts_hit = |dec;

  // Scan offsets from the pointer; the first eligible index wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_vld && eligible[i] && (i == (int'(ptr) + k) % NUM_REQ)) begin
          grant_vld = 1'b1;
          grant_idx = PW'(i);
        end
      end
    end
  end

  always_comb begin
    cmd_sel = '0;
    grant   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == PW'(i)) begin
        cmd_sel = pi_req_command[i*72 +: 72];
        grant[i] = grant_vld && (state == IDLE);
      end
    end
  end

  // The requester's own TAG/reserved bits are replaced, so they are never consumed.
  assign unused_cmd_tag = ^cmd_sel[71:64];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_vld) state_next = ISSUE;
      ISSUE:   if (pi_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ptr               <= '0;
      po_command        <= '0;
      po_req_ready      <= '0;
      po_req_sts_tvalid <= '0;
      po_req_sts_tdata  <= '0;
      po_sts_tready     <= 1'b0;
      po_orphan_sts     <= 1'b0;
      po_busy           <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= 4'd0;
    end else begin
      po_sts_tready     <= 1'b1;
      po_req_ready      <= grant;
      po_req_sts_tvalid <= dec;
      po_busy           <= (state == ISSUE) | any_cnt;
      if (state == IDLE && grant_vld) begin
        po_command <= {4'h0, 4'(grant_idx), cmd_sel[63:0]};
        ptr        <= PW'((int'(grant_idx) + 1) % NUM_REQ);
      end
      if (sts_hit) po_req_sts_tdata <= pi_sts_tdata;
      if (sts_fire && !sts_hit) po_orphan_sts <= 1'b1;
      // Grant only when below the limit and decrement only when nonzero, so no wrap either way.
      for (int i = 0; i < NUM_REQ; i++)
        cnt[i] <= cnt[i] + {3'b000, grant[i]} - {3'b000, dec[i]};
    end
  end

endmodule

// File: tb/tb_datamover_cmd_arbiter.sv
// Directed bench for datamover_cmd_arbiter (NUM_REQ=2, MAX_OUTSTANDING=4).
module tb_datamover_cmd_arbiter;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic [143:0] pi_req_command;
  logic [1:0]   pi_req_valid;
  logic [1:0]   po_req_ready;
  logic [7:0]   po_req_sts_tdata;
  logic [1:0]   po_req_sts_tvalid;
  logic [71:0]  po_command;
  logic         po_valid;
  logic         pi_ready;
  logic [7:0]   pi_sts_tdata;
  logic         pi_sts_tvalid;
  logic         po_sts_tready;
  logic         po_orphan_sts;
  logic         po_busy;

  always #5 ACLK = ~ACLK;

  datamover_cmd_arbiter #(.NUM_REQ(2), .MAX_OUTSTANDING(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .pi_req_command(pi_req_command), .pi_req_valid(pi_req_valid),
    .po_req_ready(po_req_ready), .po_req_sts_tdata(po_req_sts_tdata),
    .po_req_sts_tvalid(po_req_sts_tvalid), .po_command(po_command),
    .po_valid(po_valid), .pi_ready(pi_ready), .pi_sts_tdata(pi_sts_tdata),
    .pi_sts_tvalid(pi_sts_tvalid), .po_sts_tready(po_sts_tready),
    .po_orphan_sts(po_orphan_sts), .po_busy(po_busy)
  );

  // Requester commands carry junk in [71:64]; the issued form has 0 and the index there.
  localparam logic [71:0] CMD0     = 72'hAF_1000_0000_0080_0100;
  localparam logic [71:0] CMD1     = 72'h5C_2000_0040_0080_0200;
  localparam logic [71:0] EXP_CMD0 = 72'h00_1000_0000_0080_0100;
  localparam logic [71:0] EXP_CMD1 = 72'h01_2000_0040_0080_0200;

  typedef struct {
    logic       rst;
    logic [1:0] rv;
    logic       rdy;
    logic       sv;
    logic [7:0] sd;
    logic [1:0] e_rr;
    logic       e_vld;
    logic       e_idx;
    logic [1:0] e_svld;
    logic [7:0] e_sdat;
    logic       e_trdy;
    logic       e_orph;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   g0, g1;

  function automatic vec_t mk(logic rst, logic [1:0] rv, logic rdy, logic sv, logic [7:0] sd,
                              logic [1:0] e_rr, logic e_vld, logic e_idx, logic [1:0] e_svld,
                              logic [7:0] e_sdat, logic e_trdy, logic e_orph);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rdy = rdy; v.sv = sv; v.sd = sd;
    v.e_rr = e_rr; v.e_vld = e_vld; v.e_idx = e_idx; v.e_svld = e_svld;
    v.e_sdat = e_sdat; v.e_trdy = e_trdy; v.e_orph = e_orph;
    return v;
  endfunction

  function automatic logic [71:0] exp_cmd(logic idx);
    return idx ? EXP_CMD1 : EXP_CMD0;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_sts(input logic [7:0] sd);
    pi_sts_tvalid = 1'b1;
    pi_sts_tdata  = sd;
    step();
    pi_sts_tvalid = 1'b0;
  endtask

  task automatic reset_dut(input string tag);
    ARESET = 1'b1; pi_req_valid = 2'b00; pi_ready = 1'b0; pi_sts_tvalid = 1'b0; pi_sts_tdata = 8'h00;
    step();
    check({tag, " rst rr"},    72'(po_req_ready), 72'd0);
    check({tag, " rst valid"}, 72'(po_valid), 72'd0);
    check({tag, " rst cmd"},   po_command, 72'd0);
    check({tag, " rst svld"},  72'(po_req_sts_tvalid), 72'd0);
    check({tag, " rst sdat"},  72'(po_req_sts_tdata), 72'd0);
    check({tag, " rst trdy"},  72'(po_sts_tready), 72'd0);
    check({tag, " rst orph"},  72'(po_orphan_sts), 72'd0);
    check({tag, " rst busy"},  72'(po_busy), 72'd0);
    ARESET = 1'b0;
    step();
    check({tag, " trdy after release"}, 72'(po_sts_tready), 72'd1);
  endtask

  initial begin
    ARESET = 1'b1; pi_req_valid = 2'b00; pi_ready = 1'b0;
    pi_sts_tvalid = 1'b0; pi_sts_tdata = 8'h00;
    pi_req_command = {CMD1, CMD0};

    // reset + single command
    tbl.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 2'b01, 1'b1, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 2'b01, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b0, 1'b1, 8'h80, 2'b00, 1'b0, 1'b0, 2'b01, 8'h80, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0));
    // reset again: pointer (now 1) must return to 0
    tbl.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0));
    // round robin 0,1,0,1 with statuses (incl. SLVERR/DECERR) returned immediately
    tbl.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 8'h00, 2'b01, 1'b1, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 2'b11, 1'b1, 1'b1, 8'h80, 2'b10, 1'b1, 1'b1, 2'b01, 8'h80, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 2'b11, 1'b1, 1'b1, 8'h41, 2'b01, 1'b1, 1'b0, 2'b10, 8'h41, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 2'b11, 1'b1, 1'b1, 8'h20, 2'b10, 1'b1, 1'b1, 2'b01, 8'h20, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b0, 1'b1, 8'h81, 2'b00, 1'b0, 1'b0, 2'b10, 8'h81, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0));

    foreach (tbl[n]) begin
      ARESET = tbl[n].rst; pi_req_valid = tbl[n].rv; pi_ready = tbl[n].rdy;
      pi_sts_tvalid = tbl[n].sv; pi_sts_tdata = tbl[n].sd;
      step();
      check($sformatf("v%0d req_ready", n), 72'(po_req_ready), 72'(tbl[n].e_rr));
      check($sformatf("v%0d valid", n), 72'(po_valid), 72'(tbl[n].e_vld));
      if (tbl[n].e_vld) check($sformatf("v%0d command", n), po_command, exp_cmd(tbl[n].e_idx));
      else if (tbl[n].rst) check($sformatf("v%0d command", n), po_command, 72'd0);
      check($sformatf("v%0d sts_tvalid", n), 72'(po_req_sts_tvalid), 72'(tbl[n].e_svld));
      if (tbl[n].e_svld != 2'b00 || tbl[n].rst)
        check($sformatf("v%0d sts_tdata", n), 72'(po_req_sts_tdata), 72'(tbl[n].e_sdat));
      check($sformatf("v%0d sts_tready", n), 72'(po_sts_tready), 72'(tbl[n].e_trdy));
      check($sformatf("v%0d orphan", n), 72'(po_orphan_sts), 72'(tbl[n].e_orph));
    end
    pi_req_valid = 2'b00; pi_ready = 1'b0; pi_sts_tvalid = 1'b0;
    step();
    check("idle busy", 72'(po_busy), 72'd0);

    // back-pressure: command held for 10 cycles, req1 not granted meanwhile
    pi_req_valid = 2'b01; pi_ready = 1'b0;
    step();
    check("bp grant0", 72'(po_req_ready), 72'b01);
    pi_req_valid = 2'b10;
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("bp%0d valid", c), 72'(po_valid), 72'd1);
      check($sformatf("bp%0d command", c), po_command, EXP_CMD0);
      check($sformatf("bp%0d req_ready", c), 72'(po_req_ready), 72'd0);
    end
    check("bp busy", 72'(po_busy), 72'd1);
    pi_ready = 1'b1;
    step();
    check("bp accepted", 72'(po_valid), 72'd0);
    step();
    check("bp grant1", 72'(po_req_ready), 72'b10);
    check("bp cmd1", po_command, EXP_CMD1);
    step();
    check("bp accept1", 72'(po_valid), 72'd0);
    pi_req_valid = 2'b00;
    send_sts(8'h80);
    check("bp sts0", 72'(po_req_sts_tvalid), 72'b01);
    send_sts(8'h81);
    check("bp sts1", 72'(po_req_sts_tvalid), 72'b10);
    step(); step();
    check("bp busy drained", 72'(po_busy), 72'd0);

    // outstanding limit
    reset_dut("lim");
    pi_req_valid = 2'b01; pi_ready = 1'b1;
    g0 = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (po_req_ready[0]) g0++;
    end
    check("lim grants before stall", 72'(g0), 72'd4);
    check("lim busy", 72'(po_busy), 72'd1);
    send_sts(8'h80);
    check("lim sts routed", 72'(po_req_sts_tvalid), 72'b01);
    g0 = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (po_req_ready[0]) g0++;
    end
    check("lim fifth grant", 72'(g0), 72'd1);
    pi_req_valid = 2'b11;
    g0 = 0; g1 = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (po_req_ready[0]) g0++;
      if (po_req_ready[1]) g1++;
    end
    check("lim req1 grants", 72'(g1), 72'd4);
    check("lim req0 stalled", 72'(g0), 72'd0);
    pi_req_valid = 2'b00;

    // orphan statuses
    reset_dut("orph");
    send_sts(8'h85);
    check("orph tag5 svld", 72'(po_req_sts_tvalid), 72'd0);
    check("orph tag5 flag", 72'(po_orphan_sts), 72'd1);
    send_sts(8'h81);
    check("orph tag1 svld", 72'(po_req_sts_tvalid), 72'd0);
    step(); step();
    check("orph busy", 72'(po_busy), 72'd0);
    pi_req_valid = 2'b01; pi_ready = 1'b1;
    step();
    check("orph grant0", 72'(po_req_ready), 72'b01);
    step();
    pi_req_valid = 2'b00;
    send_sts(8'h81);
    check("orph tag1 cnt0 busy svld", 72'(po_req_sts_tvalid), 72'd0);
    send_sts(8'h80);
    check("orph cnt0 kept svld", 72'(po_req_sts_tvalid), 72'b01);
    send_sts(8'h80);
    check("orph cnt0 zero svld", 72'(po_req_sts_tvalid), 72'd0);
    step(); step(); step();
    check("orph sticky", 72'(po_orphan_sts), 72'd1);
    check("orph busy end", 72'(po_busy), 72'd0);

    // simultaneous grant and status on req0, then reset during ISSUE
    reset_dut("sim");
    pi_req_valid = 2'b01; pi_ready = 1'b1;
    step(); check("sim grantA", 72'(po_req_ready), 72'b01);
    step();
    step(); check("sim grantB", 72'(po_req_ready), 72'b01);
    step();
    pi_sts_tvalid = 1'b1; pi_sts_tdata = 8'h80;
    step();
    pi_sts_tvalid = 1'b0;
    check("sim grantC", 72'(po_req_ready), 72'b01);
    check("sim sts", 72'(po_req_sts_tvalid), 72'b01);
    step();
    pi_req_valid = 2'b00;
    step();
    send_sts(8'h80);
    check("sim drain1", 72'(po_req_sts_tvalid), 72'b01);
    send_sts(8'h80);
    check("sim drain2", 72'(po_req_sts_tvalid), 72'b01);
    send_sts(8'h80);
    check("sim drain3 orphan svld", 72'(po_req_sts_tvalid), 72'd0);
    check("sim drain3 orphan flag", 72'(po_orphan_sts), 72'd1);
    step(); step();
    check("sim busy", 72'(po_busy), 72'd0);
    pi_req_valid = 2'b01; pi_ready = 1'b0;
    step(); check("sim issue grant", 72'(po_req_ready), 72'b01);
    pi_req_valid = 2'b00;
    step(); check("sim issue held", 72'(po_valid), 72'd1);
    ARESET = 1'b1;
    step();
    check("sim rst valid", 72'(po_valid), 72'd0);
    check("sim rst busy", 72'(po_busy), 72'd0);
    check("sim rst orphan", 72'(po_orphan_sts), 72'd0);
    ARESET = 1'b0; pi_req_valid = 2'b11; pi_ready = 1'b1;
    step();
    check("sim ptr restart", 72'(po_req_ready), 72'b01);
    check("sim restart cmd", po_command, EXP_CMD0);
    step();
    pi_req_valid = 2'b00;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
